// File: rtl/pipelined_cordic.sv
// Fully pipelined CORDIC rotator (rotation mode), one sample per clock, latency SZ+1.
// Define CORDIC_SAT_EN to saturate xout/yout instead of wrapping on overflow.
module pipelined_cordic #(
  parameter int unsigned SZ = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          angle,
  input  logic signed [SZ-1:0] xin,
  input  logic signed [SZ-1:0] yin,
  output logic signed [SZ-1:0] xout,
  output logic signed [SZ-1:0] yout
);

  localparam int unsigned IntW = SZ + 2;
  typedef logic signed [IntW-1:0] word_t;

  // Index 0 is the pre-rotation stage, index i+1 holds the result of iteration i.
  word_t       x_q [SZ+1];
  word_t       x_d [SZ+1];
  word_t       y_q [SZ+1];
  word_t       y_d [SZ+1];
  logic [31:0] z_q [SZ+1];
  logic [31:0] z_d [SZ+1];

  word_t xin_ext, yin_ext;
  assign xin_ext = {{2{xin[SZ-1]}}, xin};
  assign yin_ext = {{2{yin[SZ-1]}}, yin};

  // round(atan(2^-i) * 2^32 / (2*pi))
  function automatic logic [31:0] atan_lut(input int i);
    case (i)
      0:       return 32'h2000_0000;
      1:       return 32'h12e4_051e;
      2:       return 32'h09fb_385b;
      3:       return 32'h0511_11d4;
      4:       return 32'h028b_0d43;
      5:       return 32'h0145_d7e1;
      6:       return 32'h00a2_f61e;
      7:       return 32'h0051_7c55;
      8:       return 32'h0028_be53;
      9:       return 32'h0014_5f2f;
      10:      return 32'h000a_2f98;
      11:      return 32'h0005_17cc;
      12:      return 32'h0002_8be6;
      13:      return 32'h0001_45f3;
      14:      return 32'h0000_a2fa;
      15:      return 32'h0000_517d;
      16:      return 32'h0000_28be;
      17:      return 32'h0000_145f;
      18:      return 32'h0000_0a30;
      19:      return 32'h0000_0518;
      20:      return 32'h0000_028c;
      21:      return 32'h0000_0146;
      22:      return 32'h0000_00a3;
      23:      return 32'h0000_0051;
      24:      return 32'h0000_0029;
      25:      return 32'h0000_0014;
      26:      return 32'h0000_000a;
      27:      return 32'h0000_0005;
      28:      return 32'h0000_0003;
      29:      return 32'h0000_0001;
      30:      return 32'h0000_0001;
      default: return 32'h0000_0000;
    endcase
  endfunction

  always_comb begin
    // Fold quadrants 1 and 2 into the +/-90 degree range the iterations can reach.
    x_d[0] = xin_ext;
    y_d[0] = yin_ext;
    z_d[0] = angle;
    case (angle[31:30])
      2'b01: begin
        x_d[0] = -yin_ext;
        y_d[0] = xin_ext;
        z_d[0] = {2'b00, angle[29:0]};
      end
      2'b10: begin
        x_d[0] = yin_ext;
        y_d[0] = -xin_ext;
        z_d[0] = {2'b11, angle[29:0]};
      end
      default: ;
    endcase

    for (int i = 0; i < int'(SZ); i++) begin
      if (z_q[i][31]) begin
        x_d[i+1] = x_q[i] + (y_q[i] >>> i);
        y_d[i+1] = y_q[i] - (x_q[i] >>> i);
        z_d[i+1] = z_q[i] + atan_lut(i);
      end else begin
        x_d[i+1] = x_q[i] - (y_q[i] >>> i);
        y_d[i+1] = y_q[i] + (x_q[i] >>> i);
        z_d[i+1] = z_q[i] - atan_lut(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= int'(SZ); i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
        z_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i <= int'(SZ); i++) begin
        x_q[i] <= x_d[i];
        y_q[i] <= y_d[i];
        z_q[i] <= z_d[i];
      end
    end
  end

`ifdef CORDIC_SAT_EN
  localparam word_t SatMax = word_t'((1 << (SZ - 1)) - 1);
  localparam word_t SatMin = word_t'(-(1 << (SZ - 1)));

  function automatic logic signed [SZ-1:0] sat(input word_t v);
    if (v > SatMax) begin
      return {1'b0, {(SZ-1){1'b1}}};
    end else if (v < SatMin) begin
      return {1'b1, {(SZ-1){1'b0}}};
    end else begin
      return v[SZ-1:0];
    end
  endfunction

  assign xout = sat(x_q[SZ]);
  assign yout = sat(y_q[SZ]);
`else
  assign xout = x_q[SZ][SZ-1:0];
  assign yout = y_q[SZ][SZ-1:0];
`endif

endmodule

// File: tb/tb_pipelined_cordic.sv
// Directed self-checking bench for pipelined_cordic: reset, quadrants, latency, sweep, overflow.
module tb_pipelined_cordic;

  localparam int Sz  = 16;
  localparam int Lat = Sz + 1;
  localparam real Amp = 31995.0;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [31:0]          angle = '0;
  logic signed [Sz-1:0] xin = '0;
  logic signed [Sz-1:0] yin = '0;
  logic signed [Sz-1:0] xout;
  logic signed [Sz-1:0] yout;

  int n_checks = 0;
  int n_fail   = 0;

  pipelined_cordic #(.SZ(Sz)) u_dut (
    .clk  (clk),
    .rst  (rst),
    .angle(angle),
    .xin  (xin),
    .yin  (yin),
    .xout (xout),
    .yout (yout)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp, input int tol);
    int diff;
    n_checks++;
    diff = got - exp;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int rnd(input real r);
    if (r >= 0.0) return $rtoi(r + 0.5);
    return -$rtoi(-r + 0.5);
  endfunction

  function automatic logic [31:0] deg_angle(input int d);
    logic [63:0] t;
    t = (64'h1_0000_0000 * 64'(d)) / 64'd360;
    return t[31:0];
  endfunction

  // One sample surrounded by zeros; output must still be 0 at edge 16 and valid at edge 17.
  task automatic run_vec(input string tag, input logic [31:0] ang, input int x, input int y,
                         input int xe, input int ye);
    step();
    angle = ang;
    xin   = x[Sz-1:0];
    yin   = y[Sz-1:0];
    step();
    angle = '0;
    xin   = '0;
    yin   = '0;
    repeat (Lat - 2) step();
    check_val({tag, "_x_early"}, int'(xout), 0, 0);
    check_val({tag, "_y_early"}, int'(yout), 0, 0);
    step();
    check_val({tag, "_x"}, int'(xout), xe, 8);
    check_val({tag, "_y"}, int'(yout), ye, 8);
  endtask

  initial begin
    int  j;
    real th;

    // Reset state
    #1 rst = 1'b1;
    #1;
    check_val("rst_x", int'(xout), 0, 0);
    check_val("rst_y", int'(yout), 0, 0);
    repeat (3) step();
    rst = 1'b0;

    run_vec("a0",   32'h0000_0000, 19429, 0, 31995, 0);
    run_vec("a90",  32'h4000_0000, 19429, 0, 0, 31995);
    run_vec("a180", 32'h8000_0000, 19429, 0, -31995, 0);
    run_vec("a270", 32'hC000_0000, 19429, 0, 0, -31995);
    run_vec("a45",  32'h2000_0000, 19429, 0, 22624, 22624);
    run_vec("amax", 32'hFFFF_FFFF, 19429, 0, 31995, 0);
`ifdef CORDIC_SAT_EN
    run_vec("ovf",  32'h2000_0000, 32767, 32767, 0, 32767);
`else
    // K*32767*sqrt(2) ~= 76310, wraps to ~10774
    run_vec("ovf",  32'h2000_0000, 32767, 32767, 0, 10774);
`endif

    // Mid-stream reset: fill the pipe, then reset between edges
    for (int k = 0; k < Lat + 3; k++) begin
      step();
      angle = 32'h0;
      xin   = 16'sd19429;
      yin   = '0;
    end
    check_val("pre_rst_x", int'(xout), 31995, 8);
    #2 rst = 1'b1;
    #1;
    check_val("mid_rst_x", int'(xout), 0, 0);
    check_val("mid_rst_y", int'(yout), 0, 0);
    angle = '0;
    xin   = '0;
    yin   = '0;
    step();
    step();
    rst = 1'b0;

    // Back-to-back sweep, one degree per clock
    for (int k = 0; k < 360 + Lat; k++) begin
      step();
      if (k >= Lat) begin
        j  = k - Lat;
        th = real'(j) * 3.14159265358979 / 180.0;
        check_val($sformatf("sweep%0d_x", j), int'(xout), rnd(Amp * $cos(th)), 8);
        check_val($sformatf("sweep%0d_y", j), int'(yout), rnd(Amp * $sin(th)), 8);
      end else begin
        check_val($sformatf("post_rst%0d_x", k), int'(xout), 0, 0);
        check_val($sformatf("post_rst%0d_y", k), int'(yout), 0, 0);
      end
      if (k < 360) begin
        angle = deg_angle(k);
        xin   = 16'sd19429;
        yin   = '0;
      end else begin
        angle = '0;
        xin   = '0;
        yin   = '0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_cordic.md
Name: pipelined_cordic

Overview:
- Fully pipelined CORDIC rotator in rotation mode.
- Rotates a signed 2-D vector (xin, yin) by a 32-bit binary angle; accepts one new sample every clock.
- Used as a sin/cos generator: drive xin = A/1.647 and yin = 0 to get xout ≈ A·cos θ and yout ≈ A·sin θ.
- Sits in the datapath with no handshake; downstream logic tracks the fixed latency.

Parameters:
- SZ, 16, width of xin/yin/xout/yout and number of CORDIC iteration stages.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- angle  input  32  unsigned binary angle; 2^32 = 360°, e.g. 0x20000000 = 45°.
- xin  input  SZ  signed two's-complement X component.
- yin  input  SZ  signed two's-complement Y component.
- xout  output  SZ  signed rotated X, scaled by CORDIC gain K ≈ 1.64676.
- yout  output  SZ  signed rotated Y, scaled by K.
- Port order: clk, rst, angle, xin, yin, xout, yout.

Behaviour:
- Reset: rst=1 asynchronously clears every pipeline register (x, y, z of all stages), so xout = yout = 0 immediately. Registers reload on the first rising edge after rst falls.
- Internal x/y width is SZ+2 bits signed (sign-extend inputs). Internal z width is 32 bits.
- Stage P (pre-rotation, registered), selected by angle[31:30]:
  - 00 or 11: x=xin, y=yin, z=angle.
  - 01: x=-yin, y=xin, z = angle with bits[31:30] set to 00 (angle − 90°).
  - 10: x=yin, y=-xin, z = angle with bits[31:30] set to 11 (angle + 90°).
- Stages i=0..SZ-1, each registered. Shifts are arithmetic (>>>); all sums use the SZ+2-bit width.
  - If z[31]=1: x' = x + (y>>>i), y' = y − (x>>>i), z' = z + atan[i].
  - Otherwise: x' = x − (y>>>i), y' = y + (x>>>i), z' = z − atan[i].
  - atan[i] = round(atan(2^-i) · 2^32 / 2π), stored as a 32-bit constant table (atan[0] = 0x20000000).
- Output: xout/yout are the final-stage x/y truncated to bits [SZ-1:0]. They are driven directly from the last pipeline register, with no extra output flop.
- Latency: exactly SZ+1 rising edges from sampling angle/xin/yin to the corresponding xout/yout (17 for SZ=16). Throughput is 1 sample/clock. Every input sample, including consecutive different angles, produces an independent result.
- Accuracy: |error| ≤ SZ/2 LSB versus K·(xin·cos θ − yin·sin θ) and K·(xin·sin θ + yin·cos θ), for inputs with |K·|v|| < 2^(SZ−1).
- Wrap-around: angle is modular; 0xFFFFFFFF is just below 360° and needs no special handling.
- Reset mid-stream: all in-flight samples are discarded. The first valid output appears SZ+1 edges after the first post-reset sample.

Optional Feature:
- Macro CORDIC_SAT_EN.
- Defined: the final x/y are saturated to the signed SZ-bit range [−2^(SZ−1), 2^(SZ−1)−1] before driving xout/yout.
- Undefined: plain truncation to bits [SZ-1:0]. Overflow wraps modulo 2^SZ.
- Latency is identical in both builds.

Test Plan:
- Reset: assert rst mid-operation → xout=yout=0 asynchronously, before the next edge. After release, outputs hold 0 until 17 edges after the first applied sample.
- xin=19429, yin=0, angle=0x00000000 → after exactly 17 edges, xout=31995±8, yout=0±8.
- Same xin/yin, angle=0x40000000 (90°) → xout≈0, yout≈31995; angle=0x80000000 (180°) → xout≈−31995, yout≈0; angle=0xC0000000 (270°) → yout≈−31995 (all ±8).
- angle=0x20000000 (45°), xin=19429, yin=0 → xout≈yout≈22624±8.
- Back-to-back sweep: angle=(2^32·i)/360 for i=0..359 on consecutive clocks → each result appears 17 clocks after its input and matches 31995·cos/sin(i°) within ±8. No gaps or duplicated results.
- xin=yin=0x7FFF, angle=0x20000000 → yout=0x7FFF with CORDIC_SAT_EN defined; without it, yout equals the low 16 bits of ≈76300 (wrapped). xout≈0 in both builds.
